multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle main control FSM for the processor datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath enables and memory strobes; stalls on a memory-ready handshake.
- Produces the one-hot alu_code and latched op_code consumed directly by the downstream ALU-control stage.

Parameters:
- OPW, 5, opcode width.
- ALUW, 5, alu_code width (one-hot).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ir_opcode  in  OPW  opcode field of instruction register; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- alu_code  out  ALUW  one-hot ALU class to ALU control
- op_code  out  OPW  opcode latched at DECODE
- pc_write  out  1  PC load enable
- pc_src  out  2  PC source: 0 = ALU result, 1 = branch target register, 2 = jump field
- ir_write  out  1  IR load enable
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- iord  out  1  0 = PC address, 1 = ALU-out address
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback source: 1 = memory data, 0 = ALU-out
- alu_src_b  out  2  0 = reg B, 1 = constant 1, 2 = sign-extended immediate
- halted  out  1  high in HALT
- illegal_op  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Moore FSM; all outputs combinational from the state register only, except op_code, which is a register.
- alu_code encodings, always exactly one-hot:
  - ALU_FUNC = 00001: ALU uses op_code[2:0].
  - ALU_ADD = 00010
  - ALU_SUB = 00100
  - ALU_PASS = 01000
  - ALU_CMP = 10000
- Opcode map:
  - 00xxx: R-type
  - 01000: ADDI
  - 01001: LW
  - 01010: SW
  - 01011: BEQ
  - 01100: JMP
  - 11111: HALT
  - All others are illegal.
- States and transitions:
  - RST: entered while rst = 1 and held one cycle after release. All strobes and enables 0, alu_code = ALU_ADD, op_code = 0. Then go to FETCH.
  - FETCH: mem_read = 1, iord = 0, ir_write = 1, alu_src_b = 1, alu_code = ALU_ADD, pc_src = 0. Hold with ir_write and pc_write at 0 until mem_ready = 1; in that cycle ir_write = 1 and pc_write = 1, then go to DECODE.
  - DECODE: alu_src_b = 2, alu_code = ALU_ADD (branch target), op_code <= ir_opcode. Dispatch:
    - R-type → EXEC_R
    - ADDI → EXEC_I
    - LW / SW → MEM_ADDR
    - BEQ → BRANCH
    - JMP → JUMP
    - HALT → HALT
    - illegal → FETCH with illegal_op = 1 for that cycle
  - EXEC_R: alu_src_b = 0, alu_code = ALU_FUNC → WB_ALU.
  - EXEC_I: alu_src_b = 2, alu_code = ALU_ADD → WB_ALU.
  - WB_ALU: reg_write = 1, mem_to_reg = 0 → FETCH.
  - MEM_ADDR: alu_src_b = 2, alu_code = ALU_ADD → MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD: mem_read = 1, iord = 1; wait for mem_ready → WB_MEM.
  - MEM_WR: mem_write = 1, iord = 1; wait for mem_ready → FETCH.
  - WB_MEM: reg_write = 1, mem_to_reg = 1 → FETCH.
  - BRANCH: alu_code = ALU_SUB, alu_src_b = 0, pc_src = 1, pc_write = zero → FETCH.
  - JUMP: pc_src = 2, pc_write = 1, alu_code = ALU_PASS → FETCH.
  - HALT: halted = 1, all strobes 0, alu_code = ALU_ADD; stays until rst.
- Latency with mem_ready always 1:
  - R-type / ADDI / SW: 4 cycles
  - LW: 5 cycles
  - BEQ / JMP: 3 cycles
- Each wait cycle on mem_ready adds 1 cycle.
- Strobe rules:
  - mem_read and mem_write never both 1.
  - Strobes held stable while waiting.
- Reset mid-operation: rst wins in any state; next state is RST. Pending memory access is abandoned and strobes drop the cycle after rst is sampled.
- ALU_CMP is reserved for later compare instructions; no current state drives it.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Enabled:
  - Adds outputs cycle_cnt [31:0] and instr_cnt [31:0].
  - cycle_cnt increments every non-RST, non-HALT cycle.
  - instr_cnt increments on each transition into FETCH from a terminal state, excluding the illegal-op path.
  - Both wrap at 2^32, clear on rst, and freeze in HALT.
- Disabled: ports and logic absent; remaining behaviour identical.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum
  - alu_code constants ALU_FUNC..ALU_CMP
  - opcode constants
  - pc_src and alu_src_b encodings
- The same constants are shared with the ALU-control stage.
- Natural sub-module: ctrl_decode, a combinational state-to-output decoder. The FSM next-state logic and op_code register stay in the top module.

Test Plan:
- rst held 3 cycles, then released, mem_ready = 1 → RST for 1 cycle, then FETCH; alu_code = 00010, strobes 0 during reset.
- R-type ir_opcode 00101, mem_ready = 1 →
  - states FETCH, DECODE, EXEC_R, WB_ALU.
  - op_code = 00101 from cycle after DECODE.
  - alu_code = 00001 in EXEC_R; reg_write = 1 only in WB_ALU.
- LW 01001, mem_ready low 2 cycles in MEM_RD →
  - MEM_RD lasts 3 cycles with mem_read = 1 and iord = 1 held.
  - WB_MEM has mem_to_reg = 1; total 7 cycles.
- BEQ 01011 →
  - with zero = 1: pc_write = 1, pc_src = 1, alu_code = 00100 in BRANCH.
  - repeated with zero = 0: pc_write = 0.
- Illegal 10001 → illegal_op pulses 1 cycle in DECODE, then FETCH; subsequent HALT 11111 keeps halted = 1 for 20 cycles until rst.
- rst asserted during MEM_WR wait → mem_write drops next cycle, FSM in RST, op_code = 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: constants shared by the multi-cycle control FSM and the
// downstream ALU-control stage (state encoding, one-hot ALU classes,
// opcode map, PC-source and ALU B-operand select encodings).
package ctrl_pkg;

  localparam int unsigned OPCODE_W   = 5;
  localparam int unsigned ALU_CODE_W = 5;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_ALU   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12
  } state_e;

  // One-hot ALU classes; ALU_FUNC defers to op_code[2:0] in ALU control.
  localparam logic [ALU_CODE_W-1:0] ALU_FUNC = 5'b00001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 5'b00010;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 5'b00100;
  localparam logic [ALU_CODE_W-1:0] ALU_PASS = 5'b01000;
  localparam logic [ALU_CODE_W-1:0] ALU_CMP  = 5'b10000;  // reserved for compare instructions

  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_LW   = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_SW   = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11111;

  localparam logic [1:0] PC_SRC_ALU = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] SRC_B_REG = 2'd0;
  localparam logic [1:0] SRC_B_ONE = 2'd1;
  localparam logic [1:0] SRC_B_IMM = 2'd2;

  // R-type occupies the whole 00xxx quadrant.
  function automatic logic op_is_rtype(input logic [OPCODE_W-1:0] op);
    return (op[4:3] == 2'b00);
  endfunction

  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
    logic legal;
    legal = op_is_rtype(op);
    case (op)
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT: legal = 1'b1;
      default: ;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational state-to-control decoder for multicycle_ctrl.
// Ports: i_state (current FSM state), i_mem_ready, i_zero, i_opcode_legal
// (legality of the IR opcode, used in DECODE); o_* datapath enables,
// memory strobes, selects, one-hot ALU class, halted and illegal-op flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e                  i_state,
  input  logic                    i_mem_ready,
  input  logic                    i_zero,
  input  logic                    i_opcode_legal,
  output logic [ALU_CODE_W-1:0]   o_alu_code,
  output logic                    o_pc_write,
  output logic [1:0]              o_pc_src,
  output logic                    o_ir_write,
  output logic                    o_mem_read,
  output logic                    o_mem_write,
  output logic                    o_iord,
  output logic                    o_reg_write,
  output logic                    o_mem_to_reg,
  output logic [1:0]              o_alu_src_b,
  output logic                    o_halted,
  output logic                    o_illegal_op
);

  // Per-state control decode; everything idle with ALU_ADD by default.
  always_comb begin
    o_alu_code   = ALU_ADD;
    o_pc_write   = 1'b0;
    o_pc_src     = PC_SRC_ALU;
    o_ir_write   = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_iord       = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src_b  = SRC_B_REG;
    o_halted     = 1'b0;
    o_illegal_op = 1'b0;
    case (i_state)
      ST_FETCH: begin
        // Read strobe held while waiting; IR/PC load only on the ready cycle.
        o_mem_read  = 1'b1;
        o_alu_src_b = SRC_B_ONE;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      ST_DECODE: begin
        o_alu_src_b  = SRC_B_IMM;
        o_illegal_op = ~i_opcode_legal;
      end
      ST_EXEC_R: begin
        o_alu_src_b = SRC_B_REG;
        o_alu_code  = ALU_FUNC;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        o_alu_src_b = SRC_B_IMM;
      end
      ST_WB_ALU: begin
        o_reg_write = 1'b1;
      end
      ST_MEM_RD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      ST_MEM_WR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      ST_WB_MEM: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        o_alu_code  = ALU_SUB;
        o_alu_src_b = SRC_B_REG;
        o_pc_src    = PC_SRC_BR;
        o_pc_write  = i_zero;
      end
      ST_JUMP: begin
        o_alu_code = ALU_PASS;
        o_pc_src   = PC_SRC_JMP;
        o_pc_write = 1'b1;
      end
      ST_HALT: begin
        o_halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle main control FSM (fetch/decode/execute/
// memory/writeback) with mem_ready stall handshake.
// Ports: clk, rst (sync active-high), ir_opcode, zero, mem_ready in;
// alu_code (one-hot), op_code (latched in DECODE), pc_write, pc_src,
// ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, alu_src_b,
// halted, illegal_op out.
// Build option MULTICYCLE_CTRL_PERF_EN adds cycle_cnt / instr_cnt counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW  = 5,
  parameter int unsigned ALUW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  ir_opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [ALUW-1:0] alu_code,
  output logic [OPW-1:0]  op_code,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic [1:0]      alu_src_b,
  output logic            halted,
  output logic            illegal_op
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  state_e         r_state;
  logic [OPW-1:0] r_op_code;
  logic           w_opcode_legal;

  assign w_opcode_legal = op_is_legal(ir_opcode);
  assign op_code        = r_op_code;

  // State register, next-state logic and op_code latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RST;
      r_op_code <= '0;
    end else begin
      case (r_state)
        ST_RST:      r_state <= ST_FETCH;
        ST_FETCH:    if (mem_ready) r_state <= ST_DECODE;
        ST_DECODE: begin
          r_op_code <= ir_opcode;
          if (op_is_rtype(ir_opcode)) begin
            r_state <= ST_EXEC_R;
          end else begin
            case (ir_opcode)
              OP_ADDI:      r_state <= ST_EXEC_I;
              OP_LW, OP_SW: r_state <= ST_MEM_ADDR;
              OP_BEQ:       r_state <= ST_BRANCH;
              OP_JMP:       r_state <= ST_JUMP;
              OP_HALT:      r_state <= ST_HALT;
              default:      r_state <= ST_FETCH;  // illegal: flagged, refetch
            endcase
          end
        end
        ST_EXEC_R, ST_EXEC_I: r_state <= ST_WB_ALU;
        ST_WB_ALU:   r_state <= ST_FETCH;
        ST_MEM_ADDR: r_state <= (r_op_code == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD:   if (mem_ready) r_state <= ST_WB_MEM;
        ST_MEM_WR:   if (mem_ready) r_state <= ST_FETCH;
        ST_WB_MEM:   r_state <= ST_FETCH;
        ST_BRANCH:   r_state <= ST_FETCH;
        ST_JUMP:     r_state <= ST_FETCH;
        ST_HALT:     r_state <= ST_HALT;
        default:     r_state <= ST_RST;
      endcase
    end
  end

  ctrl_decode u_decode (
    .i_state        (r_state),
    .i_mem_ready    (mem_ready),
    .i_zero         (zero),
    .i_opcode_legal (w_opcode_legal),
    .o_alu_code     (alu_code),
    .o_pc_write     (pc_write),
    .o_pc_src       (pc_src),
    .o_ir_write     (ir_write),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_iord         (iord),
    .o_reg_write    (reg_write),
    .o_mem_to_reg   (mem_to_reg),
    .o_alu_src_b    (alu_src_b),
    .o_halted       (halted),
    .o_illegal_op   (illegal_op)
  );

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;
  logic        w_retire;

  // Terminal states whose exit completes an instruction.
  assign w_retire = (r_state == ST_WB_ALU) || (r_state == ST_WB_MEM) ||
                    (r_state == ST_BRANCH) || (r_state == ST_JUMP)   ||
                    ((r_state == ST_MEM_WR) && mem_ready);

  // Performance counters; both wrap and hold in RST/HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if ((r_state != ST_RST) && (r_state != ST_HALT)) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control
// vectors are queued with the stimulus and compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3,
                 S_EXEC_I = 4, S_WB_ALU = 5, S_MEM_ADDR = 6, S_MEM_RD = 7,
                 S_MEM_WR = 8, S_WB_MEM = 9, S_BRANCH = 10, S_JUMP = 11,
                 S_HALT = 12;

  logic       clk;
  logic       rst;
  logic [4:0] ir_opcode;
  logic       zero;
  logic       mem_ready;
  logic [4:0] alu_code;
  logic [4:0] op_code;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic       mem_to_reg;
  logic [1:0] alu_src_b;
  logic       halted;
  logic       illegal_op;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ir_opcode  (ir_opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_code   (alu_code),
    .op_code    (op_code),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .halted     (halted),
    .illegal_op (illegal_op)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  ir;
    logic        mr;
    logic        z;
    logic [22:0] exp;
  } step_t;

  step_t sb[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    step_no = 0;

  // Layout: alu_code, op_code, pc_write, pc_src, ir_write, mem_read,
  // mem_write, iord, reg_write, mem_to_reg, alu_src_b, halted, illegal_op
  function automatic logic [22:0] dut_vec();
    return {alu_code, op_code, pc_write, pc_src, ir_write, mem_read,
            mem_write, iord, reg_write, mem_to_reg, alu_src_b, halted,
            illegal_op};
  endfunction

  function automatic logic legal(input logic [4:0] op);
    if (op[4:3] == 2'b00) return 1'b1;
    return (op == 5'b01000) || (op == 5'b01001) || (op == 5'b01010) ||
           (op == 5'b01011) || (op == 5'b01100) || (op == 5'b11111);
  endfunction

  // Expected control outputs for one cycle, straight from the state table.
  function automatic logic [22:0] exp_vec(input int st, input logic [4:0] opc,
                                          input logic z, input logic mr,
                                          input logic [4:0] ir);
    logic [4:0] alu;
    logic       pcw, irw, mrd, mwr, io, rw, m2r, hl, ill;
    logic [1:0] pcs, srcb;
    alu = 5'b00010; pcw = 0; pcs = 0; irw = 0; mrd = 0; mwr = 0; io = 0;
    rw = 0; m2r = 0; srcb = 0; hl = 0; ill = 0;
    case (st)
      S_FETCH:    begin mrd = 1; srcb = 2'd1; irw = mr; pcw = mr; end
      S_DECODE:   begin srcb = 2'd2; ill = ~legal(ir); end
      S_EXEC_R:   begin srcb = 2'd0; alu = 5'b00001; end
      S_EXEC_I:   srcb = 2'd2;
      S_WB_ALU:   rw = 1;
      S_MEM_ADDR: srcb = 2'd2;
      S_MEM_RD:   begin mrd = 1; io = 1; end
      S_MEM_WR:   begin mwr = 1; io = 1; end
      S_WB_MEM:   begin rw = 1; m2r = 1; end
      S_BRANCH:   begin alu = 5'b00100; pcs = 2'd1; pcw = z; end
      S_JUMP:     begin alu = 5'b01000; pcs = 2'd2; pcw = 1; end
      S_HALT:     hl = 1;
      default: ;
    endcase
    return {alu, opc, pcw, pcs, irw, mrd, mwr, io, rw, m2r, srcb, hl, ill};
  endfunction

  task automatic push(input logic r, input logic [4:0] ir, input logic mr,
                      input logic z, input int st, input logic [4:0] opc);
    step_t s;
    s.rst = r; s.ir = ir; s.mr = mr; s.z = z;
    s.exp = exp_vec(st, opc, z, mr, ir);
    sb.push_back(s);
  endtask

  task automatic test_reset();
    step_t s;
    push(1, 5'd0, 1, 0, S_RST, 5'd0);
    push(1, 5'd0, 1, 0, S_RST, 5'd0);
    push(1, 5'd0, 1, 0, S_RST, 5'd0);
    push(0, 5'd0, 1, 0, S_RST, 5'd0);   // held one cycle after release
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      rst = s.rst; ir_opcode = s.ir; mem_ready = s.mr; zero = s.z;
      #1;
      n_total++;
      if (dut_vec() !== s.exp)
        $display("FAIL reset step %0d: got %b expected %b", step_no, dut_vec(), s.exp);
      else n_pass++;
      step_no++;
    end
  endtask

  task automatic test_rtype();
    step_t s;
    push(0, 5'b00101, 1, 0, S_FETCH,  5'd0);
    push(0, 5'b00101, 1, 0, S_DECODE, 5'd0);
    push(0, 5'b00101, 1, 0, S_EXEC_R, 5'b00101);
    push(0, 5'b00101, 1, 0, S_WB_ALU, 5'b00101);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      rst = s.rst; ir_opcode = s.ir; mem_ready = s.mr; zero = s.z;
      #1;
      n_total++;
      if (dut_vec() !== s.exp)
        $display("FAIL rtype step %0d: got %b expected %b", step_no, dut_vec(), s.exp);
      else n_pass++;
      step_no++;
    end
  endtask

  task automatic test_addi_fetch_wait();
    step_t s;
    push(0, 5'b01000, 0, 0, S_FETCH,  5'b00101);
    push(0, 5'b01000, 0, 0, S_FETCH,  5'b00101);
    push(0, 5'b01000, 1, 0, S_FETCH,  5'b00101);
    push(0, 5'b01000, 1, 0, S_DECODE, 5'b00101);
    push(0, 5'b01000, 1, 0, S_EXEC_I, 5'b01000);
    push(0, 5'b01000, 1, 0, S_WB_ALU, 5'b01000);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      rst = s.rst; ir_opcode = s.ir; mem_ready = s.mr; zero = s.z;
      #1;
      n_total++;
      if (dut_vec() !== s.exp)
        $display("FAIL addi_wait step %0d: got %b expected %b", step_no, dut_vec(), s.exp);
      else n_pass++;
      step_no++;
    end
  endtask

  task automatic test_mem();
    step_t s;
    // LW with two wait cycles in MEM_RD: 7 cycles total.
    push(0, 5'b01001, 1, 0, S_FETCH,    5'b01000);
    push(0, 5'b01001, 1, 0, S_DECODE,   5'b01000);
    push(0, 5'b01001, 1, 0, S_MEM_ADDR, 5'b01001);
    push(0, 5'b01001, 0, 0, S_MEM_RD,   5'b01001);
    push(0, 5'b01001, 0, 0, S_MEM_RD,   5'b01001);
    push(0, 5'b01001, 1, 0, S_MEM_RD,   5'b01001);
    push(0, 5'b01001, 1, 0, S_WB_MEM,   5'b01001);
    // SW with no wait: 4 cycles.
    push(0, 5'b01010, 1, 0, S_FETCH,    5'b01001);
    push(0, 5'b01010, 1, 0, S_DECODE,   5'b01001);
    push(0, 5'b01010, 1, 0, S_MEM_ADDR, 5'b01010);
    push(0, 5'b01010, 1, 0, S_MEM_WR,   5'b01010);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      rst = s.rst; ir_opcode = s.ir; mem_ready = s.mr; zero = s.z;
      #1;
      n_total++;
      if (dut_vec() !== s.exp)
        $display("FAIL mem step %0d: got %b expected %b", step_no, dut_vec(), s.exp);
      else n_pass++;
      step_no++;
    end
  endtask

  task automatic test_branch_jump();
    step_t s;
    push(0, 5'b01011, 1, 0, S_FETCH,  5'b01010);
    push(0, 5'b01011, 1, 0, S_DECODE, 5'b01010);
    push(0, 5'b01011, 1, 1, S_BRANCH, 5'b01011);   // taken
    push(0, 5'b01011, 1, 1, S_FETCH,  5'b01011);
    push(0, 5'b01011, 1, 1, S_DECODE, 5'b01011);
    push(0, 5'b01011, 1, 0, S_BRANCH, 5'b01011);   // not taken
    push(0, 5'b01100, 1, 0, S_FETCH,  5'b01011);
    push(0, 5'b01100, 1, 0, S_DECODE, 5'b01011);
    push(0, 5'b01100, 1, 0, S_JUMP,   5'b01100);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      rst = s.rst; ir_opcode = s.ir; mem_ready = s.mr; zero = s.z;
      #1;
      n_total++;
      if (dut_vec() !== s.exp)
        $display("FAIL branch_jump step %0d: got %b expected %b", step_no, dut_vec(), s.exp);
      else n_pass++;
      step_no++;
    end
  endtask

  task automatic test_illegal_halt();
    step_t s;
    push(0, 5'b10001, 1, 0, S_FETCH,  5'b01100);
    push(0, 5'b10001, 1, 0, S_DECODE, 5'b01100);   // illegal_op pulse
    push(0, 5'b11111, 1, 0, S_FETCH,  5'b10001);
    push(0, 5'b11111, 1, 0, S_DECODE, 5'b10001);
    for (int i = 0; i < 20; i++)
      push(0, 5'b11111, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           S_HALT, 5'b11111);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      rst = s.rst; ir_opcode = s.ir; mem_ready = s.mr; zero = s.z;
      #1;
      n_total++;
      if (dut_vec() !== s.exp)
        $display("FAIL illegal_halt step %0d: got %b expected %b", step_no, dut_vec(), s.exp);
      else n_pass++;
      step_no++;
    end
  endtask

  task automatic test_reset_mid();
    step_t s;
    push(1, 5'b11111, 1, 0, S_HALT,     5'b11111);  // rst leaves HALT
    push(0, 5'b01010, 1, 0, S_RST,      5'd0);
    push(0, 5'b01010, 1, 0, S_FETCH,    5'd0);
    push(0, 5'b01010, 1, 0, S_DECODE,   5'd0);
    push(0, 5'b01010, 1, 0, S_MEM_ADDR, 5'b01010);
    push(0, 5'b01010, 0, 0, S_MEM_WR,   5'b01010);
    push(1, 5'b01010, 0, 0, S_MEM_WR,   5'b01010);  // rst during write wait
    push(0, 5'b01010, 0, 0, S_RST,      5'd0);      // write abandoned
    push(0, 5'b01010, 1, 0, S_FETCH,    5'd0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      rst = s.rst; ir_opcode = s.ir; mem_ready = s.mr; zero = s.z;
      #1;
      n_total++;
      if (dut_vec() !== s.exp)
        $display("FAIL reset_mid step %0d: got %b expected %b", step_no, dut_vec(), s.exp);
      else n_pass++;
      step_no++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    ir_opcode = 5'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    test_reset();
    test_rtype();
    test_addi_fetch_wait();
    test_mem();
    test_branch_jump();
    test_illegal_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
